// File: rtl/data_ram_resp_if.sv
// Data-bus interface between the MEM stage (master) and the data RAM responder (slave).
// Signal names are written from the responder's point of view.
// Optional macro DATA_RAM_ERR_EN adds the mem_err_o access-error signal.
interface data_ram_resp_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        mem_busy_o;
`ifdef DATA_RAM_ERR_EN
    logic        mem_err_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, mem_ready_o, mem_busy_o, mem_err_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, mem_ready_o, mem_busy_o, mem_err_o
    );
`else
    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, mem_ready_o, mem_busy_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, mem_ready_o, mem_busy_o
    );
`endif
endinterface

// File: rtl/data_ram_resp.sv
// data_ram_resp: word-organised data memory acting as responder on the MEM-stage bus.
// Each request is accepted in IDLE, held for WAIT_CYCLES extra cycles, then committed
// on the edge entering DONE, where a one-cycle ready pulse is produced.
// Optional macro DATA_RAM_ERR_EN: flags requests whose upper address bits exceed the
// array depth, suppressing the write and returning zero data with mem_err_o.
module data_ram_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input logic           clk,
    input logic           rst,
    data_ram_resp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [3:0]              sel_q;
    logic [31:0]             wdata_q;
    logic                    oor_q;
    logic [31:0]             rdata_q;
    logic                    ready_q;
    logic                    busy_q;

    logic [31:0]             mem [DEPTH];

    logic                    reqOor;
    logic                    commit;
    logic                    cmtWe;
    logic                    cmtOor;
    logic [ADDR_WIDTH-1:0]   cmtIdx;
    logic [3:0]              cmtSel;
    logic [31:0]             cmtWdata;

    logic                    unusedLowAddr;
    assign unusedLowAddr = ^bus.mem_addr_i[1:0];

`ifdef DATA_RAM_ERR_EN
    logic                    err_q;
    assign reqOor = |bus.mem_addr_i[31:ADDR_WIDTH+2];
`else
    logic                    unusedUpperAddr;
    assign unusedUpperAddr = ^bus.mem_addr_i[31:ADDR_WIDTH+2];
    assign reqOor = 1'b0;
`endif

    // Select the request being committed: with zero wait states the live bus is committed
    // on the accepting edge, otherwise the latched copy is used once the counter expires.
    always_comb begin
        commit   = 1'b0;
        cmtWe    = we_q;
        cmtOor   = oor_q;
        cmtIdx   = idx_q;
        cmtSel   = sel_q;
        cmtWdata = wdata_q;
        if (state_q == S_IDLE) begin
            cmtWe    = bus.mem_we_i;
            cmtOor   = reqOor;
            cmtIdx   = bus.mem_addr_i[ADDR_WIDTH+1:2];
            cmtSel   = bus.mem_sel_i;
            cmtWdata = bus.mem_data_i;
            commit   = bus.mem_ce_i && (WAIT_CYCLES == 0);
        end else if (state_q == S_WAIT) begin
            commit   = (cnt_q == 4'd0);
        end
    end

    // Request sequencer with registered handshake and read-data outputs; reset aborts
    // any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DATA_RAM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef DATA_RAM_ERR_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_ce_i) begin
                        we_q    <= bus.mem_we_i;
                        idx_q   <= bus.mem_addr_i[ADDR_WIDTH+1:2];
                        sel_q   <= bus.mem_sel_i;
                        wdata_q <= bus.mem_data_i;
                        oor_q   <= reqOor;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (commit) begin
                ready_q <= 1'b1;
`ifdef DATA_RAM_ERR_EN
                err_q   <= cmtOor;
`endif
                if (cmtWe || cmtOor) begin
                    rdata_q <= 32'd0;
                end else begin
                    rdata_q <= mem[cmtIdx];
                end
            end
        end
    end

    // Byte-lane write into the array on the committing edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && cmtWe && !cmtOor) begin
            for (int i = 0; i < 4; i++) begin
                if (cmtSel[i]) begin
                    mem[cmtIdx][8*i +: 8] <= cmtWdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_data_o  = rdata_q;
    assign bus.mem_ready_o = ready_q;
    assign bus.mem_busy_o  = busy_q;
`ifdef DATA_RAM_ERR_EN
    assign bus.mem_err_o   = err_q;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: bench for data_ram_resp with WAIT_CYCLES of 1 (main), 0 and 3.
// Honours DATA_RAM_ERR_EN when defined at compile time.
module tb_data_ram_resp;

    localparam int MW = 1;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    data_ram_resp_if busA ();
    data_ram_resp_if busZ ();
    data_ram_resp_if busS ();

    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(MW)) dutA (.clk(clk), .rst(rst), .bus(busA));
    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0))  dutZ (.clk(clk), .rst(rst), .bus(busZ));
    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(3))  dutS (.clk(clk), .rst(rst), .bus(busS));

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the WAIT_CYCLES=1 instance: a request taken on edge n
    // completes on edge n+MW, and the next one can be taken two edges after that.
    logic [31:0] modelMem [1024];
    int          edgeN    = 0;
    bit          pending  = 1'b0;
    int          doneEdge = 0;
    int          freeEdge = 0;
    bit          mWe;
    int          mIdx;
    logic [3:0]  mSel;
    logic [31:0] mData;
    bit          mOor;
    logic        expReady = 1'b0;
    logic        expBusy  = 1'b0;
    logic        expErr   = 1'b0;
    logic [31:0] expData  = 32'd0;
    bit          checkEn  = 1'b0;

    initial begin
        for (int i = 0; i < 1024; i++) modelMem[i] = 32'd0;
    end

    always @(posedge clk) begin
        edgeN++;
        if (rst) begin
            pending  = 1'b0;
            freeEdge = edgeN + 1;
            expReady = 1'b0;
            expBusy  = 1'b0;
            expErr   = 1'b0;
            expData  = 32'd0;
        end else begin
            expReady = 1'b0;
            expErr   = 1'b0;
            if (!pending && edgeN >= freeEdge && busA.mem_ce_i) begin
                mWe      = busA.mem_we_i;
                mIdx     = int'(busA.mem_addr_i[11:2]);
                mSel     = busA.mem_sel_i;
                mData    = busA.mem_data_i;
`ifdef DATA_RAM_ERR_EN
                mOor     = (busA.mem_addr_i[31:12] != 20'd0);
`else
                mOor     = 1'b0;
`endif
                pending  = 1'b1;
                doneEdge = edgeN + MW;
                expBusy  = 1'b1;
            end
            if (pending && edgeN == doneEdge) begin
                if (mOor) begin
                    expErr  = 1'b1;
                    expData = 32'd0;
                end else if (mWe) begin
                    for (int b = 0; b < 4; b++)
                        if (mSel[b]) modelMem[mIdx][8*b +: 8] = mData[8*b +: 8];
                    expData = 32'd0;
                end else begin
                    expData = modelMem[mIdx];
                end
                expReady = 1'b1;
                pending  = 1'b0;
                freeEdge = edgeN + 2;
            end else if (!pending && edgeN == freeEdge - 1) begin
                expBusy = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("ready", 32'(busA.mem_ready_o), 32'(expReady));
            checkOutput("busy", 32'(busA.mem_busy_o), 32'(expBusy));
            checkOutput("data", busA.mem_data_o, expData);
`ifdef DATA_RAM_ERR_EN
            checkOutput("err", 32'(busA.mem_err_o), 32'(expErr));
`endif
        end
    end

    // One request on the main instance, issued at a falling edge; returns read data and
    // error flag seen with ready, and leaves the bench in the IDLE cycle after DONE.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                                 input logic [31:0] data, output logic [31:0] rd, output logic re);
        int k;
        busA.mem_ce_i   = 1'b1;
        busA.mem_we_i   = we;
        busA.mem_addr_i = addr;
        busA.mem_sel_i  = sel;
        busA.mem_data_i = data;
        k = 0;
        rd = 32'd0;
        re = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) busA.mem_ce_i = 1'b0;
        end while (!busA.mem_ready_o && k < 20);
        checkOutput("latency", 32'(k), 32'(MW + 1));
        rd = busA.mem_data_o;
`ifdef DATA_RAM_ERR_EN
        re = busA.mem_err_o;
`endif
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        re;

    initial begin
        rst = 1'b1;
        busA.mem_ce_i = 1'b0; busA.mem_we_i = 1'b0; busA.mem_addr_i = 32'd0;
        busA.mem_sel_i = 4'd0; busA.mem_data_i = 32'd0;
        busZ.mem_ce_i = 1'b0; busZ.mem_we_i = 1'b0; busZ.mem_addr_i = 32'd0;
        busZ.mem_sel_i = 4'd0; busZ.mem_data_i = 32'd0;
        busS.mem_ce_i = 1'b0; busS.mem_we_i = 1'b0; busS.mem_addr_i = 32'd0;
        busS.mem_sel_i = 4'd0; busS.mem_data_i = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rstReady", 32'(busA.mem_ready_o), 32'd0);
        checkOutput("rstBusy", 32'(busA.mem_busy_o), 32'd0);
        checkOutput("rstData", busA.mem_data_o, 32'd0);
        rst = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);

        $display("[TB] full write and readback");
        applyStimulus(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, re);
        applyStimulus(1'b0, 32'h10, 4'h0, 32'h0, rd, re);
        checkOutput("read10", rd, 32'hDEADBEEF);

        $display("[TB] partial write and low address bits");
        applyStimulus(1'b1, 32'h10, 4'b0011, 32'h00001234, rd, re);
        checkOutput("wrData", rd, 32'd0);
        applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, rd, re);
        checkOutput("readPartial", rd, 32'hDEAD1234);
        applyStimulus(1'b0, 32'h13, 4'h0, 32'h0, rd, re);
        checkOutput("read13", rd, 32'hDEAD1234);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 32'h20, 4'hF, 32'h55AA55AA, rd, re);
        busA.mem_ce_i = 1'b1; busA.mem_we_i = 1'b1; busA.mem_addr_i = 32'h20;
        busA.mem_sel_i = 4'hF; busA.mem_data_i = 32'hCAFEF00D;
        @(negedge clk);
        busA.mem_ce_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortReady", 32'(busA.mem_ready_o), 32'd0);
        checkOutput("abortBusy", 32'(busA.mem_busy_o), 32'd0);
        checkOutput("abortData", busA.mem_data_o, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h20, 4'h0, 32'h0, rd, re);
        checkOutput("read20Kept", rd, 32'h55AA55AA);

        $display("[TB] bus changes during WAIT and back-to-back");
        busA.mem_ce_i = 1'b1; busA.mem_we_i = 1'b0; busA.mem_addr_i = 32'h10;
        @(negedge clk);
        busA.mem_we_i = 1'b1; busA.mem_addr_i = 32'h20; busA.mem_data_i = 32'hFFFFFFFF;
        busA.mem_sel_i = 4'hF;
        checkOutput("b2bWaitReady", 32'(busA.mem_ready_o), 32'd0);
        @(negedge clk);
        checkOutput("b2bDoneReady", 32'(busA.mem_ready_o), 32'd1);
        checkOutput("b2bDoneData", busA.mem_data_o, 32'hDEAD1234);
        busA.mem_we_i = 1'b0;
        @(negedge clk);
        checkOutput("b2bIdleReady", 32'(busA.mem_ready_o), 32'd0);
        checkOutput("b2bIdleBusy", 32'(busA.mem_busy_o), 32'd0);
        @(negedge clk);
        busA.mem_ce_i = 1'b0;
        checkOutput("b2bSecondBusy", 32'(busA.mem_busy_o), 32'd1);
        @(negedge clk);
        checkOutput("b2bSecondReady", 32'(busA.mem_ready_o), 32'd1);
        checkOutput("b2bSecondData", busA.mem_data_o, 32'h55AA55AA);
        @(negedge clk);

        $display("[TB] upper address bits");
        applyStimulus(1'b1, 32'h0, 4'hF, 32'h0000ABCD, rd, re);
        applyStimulus(1'b1, 32'h1000, 4'hF, 32'h11111111, rd, re);
        checkOutput("oorData", rd, 32'd0);
`ifdef DATA_RAM_ERR_EN
        checkOutput("oorErr", 32'(re), 32'd1);
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, rd, re);
        checkOutput("read0Unchanged", rd, 32'h0000ABCD);
        checkOutput("read0Err", 32'(re), 32'd0);
`else
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, rd, re);
        checkOutput("read0Aliased", rd, 32'h11111111);
`endif

        $display("[TB] latency with zero and three wait cycles");
        busZ.mem_ce_i = 1'b1; busZ.mem_addr_i = 32'h10;
        busS.mem_ce_i = 1'b1; busS.mem_addr_i = 32'h10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            busZ.mem_ce_i = 1'b0;
            busS.mem_ce_i = 1'b0;
            if (k == 1) begin
                checkOutput("w0Ready", 32'(busZ.mem_ready_o), 32'd1);
                checkOutput("w0Busy", 32'(busZ.mem_busy_o), 32'd1);
            end else if (k == 2) begin
                checkOutput("w0ReadyAfter", 32'(busZ.mem_ready_o), 32'd0);
                checkOutput("w0BusyAfter", 32'(busZ.mem_busy_o), 32'd0);
            end
            checkOutput("w3Busy", 32'(busS.mem_busy_o), 32'd1);
            checkOutput("w3Ready", 32'(busS.mem_ready_o), (k == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        checkOutput("w3ReadyAfter", 32'(busS.mem_ready_o), 32'd0);
        checkOutput("w3BusyAfter", 32'(busS.mem_busy_o), 32'd0);

        repeat (2) @(negedge clk);
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Word-organised data memory that serves as the responder on the MEM-stage data bus.
- The MEM stage initiates loads and stores. This block accepts each request, waits a fixed number of cycles, commits the write or returns the read word, and pulses ready.
- It sits beside the mem stage in the pipeline top. It provides the wait-state behaviour against which MEM-stage stall logic is developed.

Parameters:
- ADDR_WIDTH, 10, number of word-address bits; depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, extra wait cycles between request acceptance and completion; legal range 0..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_ce_i  input  1  request valid; requester holds it high until mem_ready_o.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_addr_i  input  32  byte address; the word index is mem_addr_i[ADDR_WIDTH+1:2]; bits [1:0] are ignored.
- mem_sel_i  input  4  byte-lane enables for writes; sel[i] maps to data bits [8i+7:8i].
- mem_data_i  input  32  write data.
- mem_data_o  output  32  read data.
- mem_ready_o  output  1  one-cycle completion pulse.
- mem_busy_o  output  1  high while a request is in flight (WAIT or DONE).
- mem_err_o  output  1  access error; exists only with DATA_RAM_ERR_EN.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - mem_data_o=0, mem_ready_o=0, mem_busy_o=0, mem_err_o=0, wait counter=0.
  - Memory array contents are not cleared.
  - Reset has priority over every other action on the same edge.
- State IDLE:
  - If mem_ce_i=1, accept the request: latch we, addr, sel and data into internal registers and set mem_busy_o=1.
  - If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1.
  - If WAIT_CYCLES=0, go to DONE.
  - If mem_ce_i=0, stay in IDLE.
- State WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, go to DONE.
  - Bus inputs are ignored in this state; only the latched request is used.
- Access commit: performed on the edge that enters DONE.
  - Write: for each i with latched sel[i]=1, array[idx][8i+7:8i] is updated; other lanes are unchanged. sel=0000 is a legal no-op write that still completes. mem_data_o is set to 0.
  - Read: mem_data_o = array[idx], full word; sel is ignored.
- State DONE:
  - mem_ready_o=1 for exactly this cycle.
  - Next state is always IDLE, with mem_busy_o=0 and mem_ready_o=0.
- Latency: a request accepted in cycle T completes with mem_ready_o=1 in cycle T+1+WAIT_CYCLES.
- Back-to-back requests:
  - A new request cannot be accepted before the IDLE cycle that follows DONE, so the minimum request spacing is WAIT_CYCLES+2 cycles.
  - If mem_ce_i is still high in that IDLE cycle, it is accepted as a new request. The requester must drop mem_ce_i in the DONE cycle to avoid a repeat access.
- Holding mem_data_o: keeps its value until the next commit or reset.
- Reset mid-operation (during WAIT, or on the edge that would enter DONE):
  - The request is aborted and no array write occurs.
  - No ready pulse is produced.

Optional Feature:
- Macro: DATA_RAM_ERR_EN.
- When defined, the mem_err_o port exists. An out-of-range request is one where mem_addr_i[31:ADDR_WIDTH+2] is nonzero. For such a request, on DONE:
  - mem_ready_o=1 and mem_err_o=1 for that cycle.
  - The write is suppressed and mem_data_o=0.
  - mem_err_o is otherwise 0.
- When not defined, the mem_err_o port is absent and upper address bits are ignored, so addresses alias modulo the depth.

Test Plan (ADDR_WIDTH=10, WAIT_CYCLES=1 unless stated):
- Write 0xDEADBEEF to 0x00000010 with sel=1111, request accepted in cycle T -> mem_ready_o=1 in cycle T+2 only. A following read of 0x10 returns 0xDEADBEEF, also with ready in acceptance+2.
- After the first test, write 0x00001234 to 0x10 with sel=0011 -> a read of 0x10 returns 0xDEAD1234. A read of 0x13 (low bits ignored) also returns 0xDEAD1234.
- Write 0xCAFEF00D to 0x20 with rst=1 during WAIT -> no ready pulse and all outputs 0. A read of 0x20 afterwards returns its previous contents.
- Start a read of 0x10, then during WAIT change addr to 0x20 and we to 1 -> the completion returns 0xDEAD1234 and no write to 0x20 occurs. With mem_ce_i held high through DONE, a second access starts in the following IDLE cycle.
- WAIT_CYCLES=0: a read accepted in cycle T -> ready in cycle T+1. WAIT_CYCLES=3 -> ready in cycle T+4. mem_busy_o is high in every cycle from T+1 through ready.
- With DATA_RAM_ERR_EN: write 0x11111111 to 0x00001000 -> mem_err_o=1 with ready and mem_data_o=0. A read of 0x0 afterwards returns its unchanged value. Without the macro, the same write lands at word 0.
